// File: rtl/inst_decode_pkg.sv
// Shared types and opcode constants for the RV64I decode stage.
package inst_decode_pkg;

    typedef logic [31:0] inst_t;
    typedef logic [63:0] addr_t;

    typedef enum logic [3:0] {
        OP_ALU,
        OP_ALUW,
        OP_LUI,
        OP_AUIPC,
        OP_JAL,
        OP_JALR,
        OP_BRANCH,
        OP_LOAD,
        OP_STORE,
        OP_ILLEGAL
    } dec_op_t;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    // One queued instruction together with the PC it was fetched from.
    typedef struct packed {
        inst_t inst;
        addr_t pc;
    } entry_t;

    // Every immediate format is assembled into 32 bits with inst[31] on top,
    // so widening to 64 bits is always a copy of bit 31.
    function automatic addr_t sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/inst_decode_fields.sv
// Combinational RV64I field extraction: operation class, register indices,
// sign-extended immediate and legality for one instruction word.
module inst_fields
    import inst_decode_pkg::*;
(
    input  inst_t         inst,
    output dec_op_t       op,
    output logic [4:0]    rd,
    output logic [4:0]    rs1,
    output logic [4:0]    rs2,
    output addr_t         imm,
    output logic          illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       funct7_ok;
    addr_t      imm_i;
    addr_t      imm_s;
    addr_t      imm_b;
    addr_t      imm_u;
    addr_t      imm_j;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    // Only SUB/SUBW and SRA/SRAW may carry the alternate funct7.
    assign funct7_ok = (funct7 == 7'b0000000) ||
                       ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));

    assign imm_i = sext32({{20{inst[31]}}, inst[31:20]});
    assign imm_s = sext32({{20{inst[31]}}, inst[31:25], inst[11:7]});
    assign imm_b = sext32({{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
    assign imm_u = sext32({inst[31:12], 12'b0});
    assign imm_j = sext32({{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});

    // Select fields per format; anything not recognised stays illegal with zeroed fields.
    always_comb begin
        op      = OP_ILLEGAL;
        rd      = 5'd0;
        rs1     = 5'd0;
        rs2     = 5'd0;
        imm     = '0;
        illegal = 1'b1;
        if (inst[1:0] == 2'b11) begin
            case (opcode)
                OPC_LUI: begin
                    op = OP_LUI; rd = inst[11:7]; imm = imm_u; illegal = 1'b0;
                end
                OPC_AUIPC: begin
                    op = OP_AUIPC; rd = inst[11:7]; imm = imm_u; illegal = 1'b0;
                end
                OPC_JAL: begin
                    op = OP_JAL; rd = inst[11:7]; imm = imm_j; illegal = 1'b0;
                end
                OPC_JALR: begin
                    op = OP_JALR; rd = inst[11:7]; rs1 = inst[19:15]; imm = imm_i; illegal = 1'b0;
                end
                OPC_BRANCH: begin
                    if ((funct3 != 3'b010) && (funct3 != 3'b011)) begin
                        op = OP_BRANCH; rs1 = inst[19:15]; rs2 = inst[24:20]; imm = imm_b; illegal = 1'b0;
                    end
                end
                OPC_LOAD: begin
                    if (funct3 != 3'b111) begin
                        op = OP_LOAD; rd = inst[11:7]; rs1 = inst[19:15]; imm = imm_i; illegal = 1'b0;
                    end
                end
                OPC_STORE: begin
                    if (funct3[2] == 1'b0) begin
                        op = OP_STORE; rs1 = inst[19:15]; rs2 = inst[24:20]; imm = imm_s; illegal = 1'b0;
                    end
                end
                OPC_OP_IMM: begin
                    op = OP_ALU; rd = inst[11:7]; rs1 = inst[19:15]; imm = imm_i; illegal = 1'b0;
                end
                OPC_OP_IMM_32: begin
                    op = OP_ALUW; rd = inst[11:7]; rs1 = inst[19:15]; imm = imm_i; illegal = 1'b0;
                end
                OPC_OP: begin
                    if (funct7_ok) begin
                        op = OP_ALU; rd = inst[11:7]; rs1 = inst[19:15]; rs2 = inst[24:20]; illegal = 1'b0;
                    end
                end
                OPC_OP_32: begin
                    if (funct7_ok) begin
                        op = OP_ALUW; rd = inst[11:7]; rs1 = inst[19:15]; rs2 = inst[24:20]; illegal = 1'b0;
                    end
                end
                default: begin
                    op = OP_ILLEGAL;
                end
            endcase
        end
    end

endmodule

// File: rtl/inst_decode.sv
// Decode stage: 2-entry instruction queue behind fetch, decoded head entry
// presented to execute over valid/ready, with flush and stale-fetch drop.
module inst_decode
    import inst_decode_pkg::*;
#(
    parameter int DEPTH = 2
)(
    input  logic          clk,
    input  logic          rst,
    input  inst_t         inst,
    input  addr_t         inst_pc,
    input  logic          inst_signal,
    input  logic          fetch_busy,
    input  logic          flush,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output addr_t         out_pc,
    output inst_t         out_inst,
    output dec_op_t       out_op,
    output logic [4:0]    out_rd,
    output logic [4:0]    out_rs1,
    output logic [4:0]    out_rs2,
    output addr_t         out_imm,
    output logic          out_illegal,
    output logic          overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    entry_t             entries [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;
    logic               drop;
    logic               full;
    logic               push;
    logic               pop;

    assign full      = (count == FULL);
    assign out_valid = (count != '0);
    assign in_ready  = !full;

    // A pop frees the slot that a same-cycle push needs, so full plus pop still accepts.
    assign pop  = out_valid && out_ready && !flush;
    assign push = inst_signal && !flush && !drop && (!full || pop);

    assign out_pc   = entries[head].pc;
    assign out_inst = entries[head].inst;

    inst_fields u_fields (
        .inst    (entries[head].inst),
        .op      (out_op),
        .rd      (out_rd),
        .rs1     (out_rs1),
        .rs2     (out_rs2),
        .imm     (out_imm),
        .illegal (out_illegal)
    );

    // Queue storage, pointers, occupancy, stale-fetch drop flag and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            drop     <= 1'b0;
            overflow <= 1'b0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            if (fetch_busy && !inst_signal) begin
                drop <= 1'b1;
            end
        end else begin
            if (push) begin
                entries[tail] <= '{inst: inst, pc: inst_pc};
                tail          <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
            if (inst_signal && drop) begin
                drop <= 1'b0;
            end
            if (inst_signal && !drop && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inst_decode.sv
// Self-checking bench for inst_decode: a queue-level reference model checked
// every cycle, plus literal expectations for the documented scenarios.
module tb_inst_decode;
    import inst_decode_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_signal;
    logic        fetch_busy;
    logic        flush;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    dec_op_t     out_op;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [63:0] out_imm;
    logic        out_illegal;
    logic        overflow;

    int vectors     = 0;
    int miscompares = 0;
    bit checking    = 1'b1;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
    } m_entry_t;

    typedef struct packed {
        dec_op_t     op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [63:0] imm;
        logic        illegal;
    } exp_t;

    m_entry_t mq[$];
    bit       m_drop = 1'b0;
    bit       m_ovf  = 1'b0;

    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_BEQ  = 32'hFE000EE3;
    localparam logic [31:0] I_SW   = 32'h00112623;
    localparam logic [31:0] I_JAL  = 32'h0000006F;
    localparam logic [31:0] I_LUI  = 32'h123452B7;

    logic [31:0] table_w [16] = '{
        32'h123452B7, 32'hFFFFF317, 32'hFF8100E7, 32'h01023183,
        32'h409403B3, 32'h00C5853B, 32'h00000000, 32'h0000007F,
        32'h00002063, 32'h02000033, 32'h00007003, 32'h00500092,
        32'h00004023, 32'h4000103B, 32'h0000501B, 32'h0080006F
    };

    inst_decode #(.DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_signal (inst_signal),
        .fetch_busy  (fetch_busy),
        .flush       (flush),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_inst    (out_inst),
        .out_op      (out_op),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_imm     (out_imm),
        .out_illegal (out_illegal),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Reference decode: classify by opcode into a format letter, then derive fields from the format.
    function automatic exp_t modelDecode(input logic [31:0] w);
        exp_t        e;
        byte         fmt;
        bit          ok;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] simm;
        logic [12:0] bimm;
        logic [20:0] jimm;
        f3 = w[14:12];
        f7 = w[31:25];
        e.op = OP_ILLEGAL; e.rd = 5'd0; e.rs1 = 5'd0; e.rs2 = 5'd0; e.imm = 64'd0; e.illegal = 1'b1;
        fmt = "X";
        ok  = 1'b1;
        case (w[6:0])
            7'h37: begin fmt = "U"; e.op = OP_LUI;    end
            7'h17: begin fmt = "U"; e.op = OP_AUIPC;  end
            7'h6F: begin fmt = "J"; e.op = OP_JAL;    end
            7'h67: begin fmt = "I"; e.op = OP_JALR;   end
            7'h63: begin fmt = "B"; e.op = OP_BRANCH; ok = !(f3 == 3'd2 || f3 == 3'd3); end
            7'h03: begin fmt = "I"; e.op = OP_LOAD;   ok = (f3 != 3'd7); end
            7'h23: begin fmt = "S"; e.op = OP_STORE;  ok = (f3 <= 3'd3); end
            7'h13: begin fmt = "I"; e.op = OP_ALU;    end
            7'h1B: begin fmt = "I"; e.op = OP_ALUW;   end
            7'h33: begin fmt = "R"; e.op = OP_ALU;  ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)); end
            7'h3B: begin fmt = "R"; e.op = OP_ALUW; ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)); end
            default: ok = 1'b0;
        endcase
        if (w[1:0] != 2'b11) ok = 1'b0;
        if (!ok) begin
            e.op = OP_ILLEGAL;
            return e;
        end
        e.illegal = 1'b0;
        simm = {w[31:25], w[11:7]};
        bimm = {w[31], w[7], w[30:25], w[11:8], 1'b0};
        jimm = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        if (fmt == "I") e.imm = longint'($signed(w[31:20]));
        if (fmt == "S") e.imm = longint'($signed(simm));
        if (fmt == "B") e.imm = longint'($signed(bimm));
        if (fmt == "U") e.imm = longint'($signed(w[31:12])) <<< 12;
        if (fmt == "J") e.imm = longint'($signed(jimm));
        if (fmt == "R" || fmt == "I" || fmt == "U" || fmt == "J") e.rd = w[11:7];
        if (fmt == "R" || fmt == "I" || fmt == "S" || fmt == "B") e.rs1 = w[19:15];
        if (fmt == "R" || fmt == "S" || fmt == "B") e.rs2 = w[24:20];
        return e;
    endfunction

    // Queue-level reference: what one clock edge does given this cycle's inputs.
    task automatic modelStep(input logic sig, input logic [31:0] w, input logic [63:0] pc,
                             input logic rdy, input logic fl, input logic busy, input logic rstn);
        bit do_pop;
        if (!rstn) begin
            mq.delete();
            m_drop = 1'b0;
            m_ovf  = 1'b0;
            return;
        end
        if (fl) begin
            mq.delete();
            if (busy && !sig) m_drop = 1'b1;
            return;
        end
        do_pop = (mq.size() != 0) && rdy;
        if (do_pop) void'(mq.pop_front());
        if (sig) begin
            if (m_drop) m_drop = 1'b0;
            else if (mq.size() < 2) mq.push_back('{inst: w, pc: pc});
            else m_ovf = 1'b1;
        end
    endtask

    task automatic checkVal(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare every observable output against the model.
    task automatic checkOutput();
        exp_t e;
        checkVal("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        checkVal("in_ready",  64'(in_ready),  64'(mq.size() != 2));
        checkVal("overflow",  64'(overflow),  64'(m_ovf));
        if (mq.size() != 0) begin
            e = modelDecode(mq[0].inst);
            checkVal("out_pc",      out_pc,            mq[0].pc);
            checkVal("out_inst",    64'(out_inst),     64'(mq[0].inst));
            checkVal("out_op",      64'(out_op),       64'(e.op));
            checkVal("out_rd",      64'(out_rd),       64'(e.rd));
            checkVal("out_rs1",     64'(out_rs1),      64'(e.rs1));
            checkVal("out_rs2",     64'(out_rs2),      64'(e.rs2));
            checkVal("out_imm",     out_imm,           e.imm);
            checkVal("out_illegal", 64'(out_illegal),  64'(e.illegal));
        end
    endtask

    always @(negedge clk) begin
        if (checking) checkOutput();
    end

    task automatic applyStimulus(input logic sig, input logic [31:0] w, input logic [63:0] pc,
                                 input logic rdy, input logic fl = 1'b0, input logic busy = 1'b0,
                                 input logic rstn = 1'b1);
        inst_signal = sig;
        inst        = w;
        inst_pc     = pc;
        out_ready   = rdy;
        flush       = fl;
        fetch_busy  = busy;
        rst         = rstn;
        @(posedge clk);
        modelStep(sig, w, pc, rdy, fl, busy, rstn);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        applyStimulus(1'b0, 32'h0, 64'h0, rdy);
    endtask

    initial begin
        // Reset
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkVal("rst_valid",   64'(out_valid), 64'd0);
        checkVal("rst_inready", 64'(in_ready),  64'd1);
        checkVal("rst_ovf",     64'(overflow),  64'd0);
        checkVal("rst_pc",      out_pc,         64'd0);
        checkVal("rst_inst",    64'(out_inst),  64'd0);

        // Single push, visible next cycle
        applyStimulus(1'b1, I_ADDI, 64'h8000_0000, 1'b0);
        checkVal("addi_valid", 64'(out_valid), 64'd1);
        checkVal("addi_op",    64'(out_op),    64'(OP_ALU));
        checkVal("addi_rd",    64'(out_rd),    64'd1);
        checkVal("addi_rs1",   64'(out_rs1),   64'd0);
        checkVal("addi_imm",   out_imm,        64'd5);

        // Fill, then overflow while full
        applyStimulus(1'b1, I_BEQ, 64'h8000_0004, 1'b0);
        checkVal("full_inready", 64'(in_ready), 64'd0);
        applyStimulus(1'b1, I_SW, 64'h8000_0008, 1'b0);
        checkVal("ovf_set",   64'(overflow), 64'd1);
        checkVal("ovf_head",  64'(out_inst), 64'(I_ADDI));

        // Drain in order
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1);
        checkVal("beq_pc",  out_pc,        64'h8000_0004);
        checkVal("beq_op",  64'(out_op),   64'(OP_BRANCH));
        checkVal("beq_imm", out_imm,       64'hFFFF_FFFF_FFFF_FFFC);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1);
        checkVal("drained", 64'(out_valid), 64'd0);

        // Store and jump immediates
        applyStimulus(1'b1, I_SW, 64'h8000_0100, 1'b0);
        checkVal("sw_op",  64'(out_op),  64'(OP_STORE));
        checkVal("sw_imm", out_imm,      64'd12);
        checkVal("sw_rs2", 64'(out_rs2), 64'd1);
        checkVal("sw_rs1", 64'(out_rs1), 64'd2);
        checkVal("sw_rd",  64'(out_rd),  64'd0);
        applyStimulus(1'b1, I_JAL, 64'h8000_0104, 1'b1);
        checkVal("jal_inst", 64'(out_inst), 64'(I_JAL));
        checkVal("jal_op",   64'(out_op),   64'(OP_JAL));
        checkVal("jal_imm",  out_imm,       64'd0);

        // Back-to-back stream of legal and illegal encodings at full throughput
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, table_w[i], 64'h8000_0200 + 64'(4 * i), 1'b1);
        end
        idle(1'b1);

        // Flush while fetch is still in flight: next pulse is stale
        applyStimulus(1'b1, I_ADDI, 64'h8000_0300, 1'b0);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b0, 1'b1, 1'b1);
        checkVal("flush_valid", 64'(out_valid), 64'd0);
        applyStimulus(1'b1, I_LUI, 64'h8000_0304, 1'b0);
        checkVal("drop_valid", 64'(out_valid), 64'd0);
        applyStimulus(1'b1, I_ADDI, 64'h9000_0000, 1'b0);
        checkVal("after_drop_valid", 64'(out_valid), 64'd1);
        checkVal("after_drop_pc",    out_pc,         64'h9000_0000);
        idle(1'b1);

        // Clear sticky overflow, then push+pop while full
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, I_ADDI, 64'hA000_0000, 1'b0);
        applyStimulus(1'b1, I_SW,   64'hA000_0004, 1'b0);
        applyStimulus(1'b1, I_BEQ,  64'hA000_0008, 1'b1);
        checkVal("pp_inready", 64'(in_ready), 64'd0);
        checkVal("pp_ovf",     64'(overflow), 64'd0);
        checkVal("pp_pc",      out_pc,        64'hA000_0004);

        // Reset mid-operation with a full queue, overflow set and flush pending
        applyStimulus(1'b1, I_JAL, 64'hA000_000C, 1'b0);
        checkVal("mid_ovf", 64'(overflow), 64'd1);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkVal("mid_valid",   64'(out_valid), 64'd0);
        checkVal("mid_inready", 64'(in_ready),  64'd1);
        checkVal("mid_ovf0",    64'(overflow),  64'd0);
        checkVal("mid_pc",      out_pc,         64'd0);
        checkVal("mid_inst",    64'(out_inst),  64'd0);
        applyStimulus(1'b1, I_ADDI, 64'hB000_0000, 1'b0);
        checkVal("mid_accept", 64'(out_valid), 64'd1);

        // Reset clears a pending drop
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, I_SW, 64'hC000_0000, 1'b0);
        checkVal("rstdrop_accept", 64'(out_valid), 64'd1);
        checkVal("rstdrop_pc",     out_pc,         64'hC000_0000);
        idle(1'b1);
        idle(1'b1);

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
